// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, kernel geometry and FSM encoding for the 3x3 convolution stage
package conv_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ROW_LEN  = 8;
  localparam int DEF_ACC_W    = DEF_DATA_W + DEF_WEIGHT_W + 5;
  localparam int KSIZE        = 3;
  localparam int NTAP         = KSIZE * KSIZE;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
endpackage

// File: rtl/conv3x3_dot.sv
// conv3x3_dot: 9 registered products then a registered adder tree, fixed 2-cycle latency with tags
module conv3x3_dot import conv_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DATA_W + WEIGHT_W + 5
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NTAP-1:0][DATA_W-1:0]        i_pix,
  input  logic [NTAP-1:0][WEIGHT_W-1:0]      i_wgt,
  input  logic                               i_valid,
  input  logic                               i_last,
  output logic signed [ACC_W-1:0]            o_sum,
  output logic                               o_valid,
  output logic                               o_last
);
  localparam int PW = DATA_W + WEIGHT_W + 1;
  logic signed [PW-1:0]    w_prod [NTAP];
  logic signed [PW-1:0]    r_prod [NTAP];
  logic signed [ACC_W-1:0] w_sum;
  logic                    r_v1;
  logic                    r_l1;
  // pixels are unsigned, so a zero bit is prepended before the signed multiply
  always_comb begin
    w_sum = '0;
    for (int n = 0; n < NTAP; n++) begin
      w_prod[n] = PW'($signed({1'b0, i_pix[n]})) * PW'($signed(i_wgt[n]));
      w_sum = w_sum + ACC_W'(r_prod[n]);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod  <= '{default: '0};
      r_v1    <= 1'b0;
      r_l1    <= 1'b0;
      o_sum   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      r_prod  <= w_prod;
      r_v1    <= i_valid;
      r_l1    <= i_last;
      o_valid <= r_v1;
      o_last  <= r_l1;
      if (r_v1) o_sum <= w_sum;
    end
  end
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: streams three BRAM rows through a sliding 3x3 window and emits one signed
// dot product per complete window, then pulses conv_done back to the line-buffer controller
module conv3x3_mac import conv_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ROW_LEN  = DEF_ROW_LEN,
  parameter int ACC_W    = DATA_W + WEIGHT_W + 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_compute_conv,
  input  logic                       i_wgt_wr,
  input  logic [3:0]                 i_wgt_addr,
  input  logic [WEIGHT_W-1:0]        i_wgt_data,
  input  logic [DATA_W-1:0]          i_row0_data,
  input  logic [DATA_W-1:0]          i_row1_data,
  input  logic [DATA_W-1:0]          i_row2_data,
  output logic                       o_rd_en,
  output logic [$clog2(ROW_LEN)-1:0] o_rd_addr,
  output logic                       o_busy,
  output logic signed [ACC_W-1:0]    o_result,
  output logic                       o_result_valid,
  output logic                       o_conv_done
);
  localparam int AW = $clog2(ROW_LEN);
  localparam logic [AW-1:0] K_LAST = AW'(ROW_LEN - 1);
  state_t                                  r_state;
  logic [AW-1:0]                           r_k;
  logic                                    r_rd_v;
  logic                                    r_rd_ge2;
  logic                                    r_rd_last;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] r_win;
  logic                                    r_win_v;
  logic                                    r_win_last;
  logic [NTAP-1:0][WEIGHT_W-1:0]           r_wgt;
  logic                                    w_last;
  assign o_rd_en     = r_state == READ;
  assign o_rd_addr   = r_k;
  assign o_busy      = r_state != IDLE;
  assign o_conv_done = o_result_valid & w_last;
  // the ge2/last tags ride one cycle behind the address so they line up with the returned BRAM word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_rd_v     <= 1'b0;
      r_rd_ge2   <= 1'b0;
      r_rd_last  <= 1'b0;
      r_win      <= '0;
      r_win_v    <= 1'b0;
      r_win_last <= 1'b0;
      r_wgt      <= '0;
    end else begin
      r_state    <= r_state == IDLE ? (i_compute_conv ? READ : IDLE) :
                    r_state == READ ? (r_k == K_LAST ? DRAIN : READ) :
                    (o_conv_done ? IDLE : DRAIN);
      r_k        <= (o_rd_en && r_k != K_LAST) ? r_k + AW'(1) : '0;
      r_rd_v     <= o_rd_en;
      r_rd_ge2   <= r_k >= AW'(2);
      r_rd_last  <= r_k == K_LAST;
      r_win_v    <= r_rd_v & r_rd_ge2;
      r_win_last <= r_rd_v & r_rd_last;
      if (r_rd_v) r_win <= {{i_row2_data, r_win[2][2:1]}, {i_row1_data, r_win[1][2:1]}, {i_row0_data, r_win[0][2:1]}};
      if (r_state == IDLE && i_wgt_wr && i_wgt_addr < 4'(NTAP)) r_wgt[i_wgt_addr] <= i_wgt_data;
    end
  end
  conv3x3_dot #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)) u_dot (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_pix  (r_win),
    .i_wgt  (r_wgt),
    .i_valid(r_win_v),
    .i_last (r_win_last),
    .o_sum  (o_result),
    .o_valid(o_result_valid),
    .o_last (w_last)
  );
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: table vectors, randomized runs against an arithmetic reference, and
// hand-written sequences for busy-time restarts, back-to-back runs and mid-run reset
module tb_conv3x3_mac;
  import conv_pkg::*;
  localparam int RL = 8;
  localparam int AW = 3;
  localparam int AC = DEF_ACC_W;
  typedef struct {
    int     w[9];
    int     mode;
    longint exp[RL-2];
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          wr = 1'b0;
  logic [3:0]    waddr = '0;
  logic [7:0]    wdata = '0;
  logic [7:0]    r0 = '0;
  logic [7:0]    r1 = '0;
  logic [7:0]    r2 = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic [AC-1:0] res;
  logic          vld;
  logic          done;
  int            mem[3][RL];
  int            wm[9];
  longint        expv[RL-2];
  vec_t          tbl[3];
  int            n_chk = 0;
  int            n_fail = 0;

  conv3x3_mac dut (
    .i_clk(clk), .i_rst(rst), .i_compute_conv(start), .i_wgt_wr(wr), .i_wgt_addr(waddr),
    .i_wgt_data(wdata), .i_row0_data(r0), .i_row1_data(r1), .i_row2_data(r2),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .o_busy(busy), .o_result(res),
    .o_result_valid(vld), .o_conv_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) begin
    r0 <= 8'(mem[0][rd_addr]);
    r1 <= 8'(mem[1][rd_addr]);
    r2 <= 8'(mem[2][rd_addr]);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < RL; a++)
        mem[r][a] = mode == 0 ? a + 1 : mode == 1 ? (r == 1 ? 10 * a : 255) :
                    mode == 2 ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic load_w;
    for (int n = 0; n < 9; n++) begin
      wr = 1'b1; waddr = 4'(n); wdata = 8'(wm[n]);
      step;
    end
    wr = 1'b0;
  endtask

  task automatic model;
    for (int j = 2; j < RL; j++) begin
      longint s = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s += longint'(wm[3 * r + c]) * longint'(mem[r][j - 2 + c]);
      expv[j - 2] = s;
    end
  endtask

  task automatic run_op(input string nm, input int inj, input bit sw);
    int nrd = 0, nv = 0, nd = 0, c;
    start = 1'b1;
    if (sw) begin wr = 1'b1; waddr = 4'd4; wdata = 8'd3; end
    step;
    start = 1'b0; wr = 1'b0;
    for (c = 1; c <= 40; c++) begin
      if (c == 1) chk({nm, ":busy_on"}, longint'(busy), 1);
      if (rd_en) begin
        chk({nm, ":rd_addr"}, longint'(rd_addr), nrd);
        chk({nm, ":rd_cycle"}, c, nrd + 1);
        nrd++;
      end
      if (vld) begin
        chk({nm, ":result"}, longint'($signed(res)), expv[nv < RL - 2 ? nv : RL - 3]);
        chk({nm, ":result_cycle"}, c, nv + 7);
        nv++;
      end
      if (done) begin
        nd++;
        chk({nm, ":done_with_last"}, nv, RL - 2);
        chk({nm, ":done_with_valid"}, longint'(vld), 1);
      end
      if (!busy) break;
      if (c == inj) begin start = 1'b1; wr = 1'b1; waddr = 4'd4; wdata = 8'd7; end
      step;
      start = 1'b0; wr = 1'b0;
    end
    chk({nm, ":n_reads"}, nrd, RL);
    chk({nm, ":n_valid"}, nv, RL - 2);
    chk({nm, ":n_done"}, nd, 1);
    chk({nm, ":busy_off_cycle"}, c, RL + 5);
  endtask

  initial begin
    int nd;
    tbl[0].w = '{default: 1};
    tbl[0].mode = 0;
    tbl[0].exp = '{18, 27, 36, 45, 54, 63};
    tbl[1].w = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1].mode = 1;
    tbl[1].exp = '{10, 20, 30, 40, 50, 60};
    tbl[2].w = '{default: -1};
    tbl[2].mode = 2;
    tbl[2].exp = '{default: -2295};
    fill(0);
    repeat (3) step;
    chk("reset:rd_en", longint'(rd_en), 0);
    chk("reset:rd_addr", longint'(rd_addr), 0);
    chk("reset:busy", longint'(busy), 0);
    chk("reset:valid", longint'(vld), 0);
    chk("reset:done", longint'(done), 0);
    chk("reset:result", longint'(res), 0);
    rst = 1'b0;
    step;
    for (int i = 0; i < 3; i++) begin
      wm = tbl[i].w;
      fill(tbl[i].mode);
      load_w;
      if (i == 0)
        for (int a = 9; a < 16; a += 3) begin
          wr = 1'b1; waddr = 4'(a); wdata = 8'h55;
          step;
        end
      wr = 1'b0;
      expv = tbl[i].exp;
      run_op($sformatf("tbl%0d", i), -1, 1'b0);
    end
    run_op("busy_restart", 3, 1'b0);
    run_op("back_to_back", -1, 1'b0);
    wm[4] = 3;
    model;
    run_op("start_with_wr", -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 9; n++) wm[n] = int'($urandom_range(0, 255)) - 128;
      fill(3);
      load_w;
      model;
      run_op($sformatf("rand%0d", i), -1, 1'b0);
    end
    wm = '{default: 1};
    fill(0);
    load_w;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 20 && !(rd_en && rd_addr == 3'd4); i++) step;
    chk("mid_rst:reached_k4", longint'(rd_addr), 4);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst:rd_en", longint'(rd_en), 0);
    chk("mid_rst:rd_addr", longint'(rd_addr), 0);
    chk("mid_rst:busy", longint'(busy), 0);
    chk("mid_rst:valid", longint'(vld), 0);
    chk("mid_rst:done", longint'(done), 0);
    chk("mid_rst:result", longint'(res), 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      step;
    end
    chk("mid_rst:no_done", nd, 0);
    wm = '{default: 0};
    model;
    run_op("post_rst_zero_w", -1, 1'b0);
    for (int n = 0; n < 9; n++) wm[n] = int'($urandom_range(0, 255)) - 128;
    fill(3);
    load_w;
    model;
    run_op("post_rst_reload", -1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Compute stage directly downstream of the line-buffer controller.
- Started by the controller's one-cycle `compute_conv` pulse.
- Reads one column per cycle from the three row BRAMs (row0 oldest, row2 newest) and slides a 3x3 window along the rows.
- Produces one signed convolution result per window position, then returns a one-cycle `conv_done` pulse to the controller.
- Holds a 9-entry signed kernel register file, loaded while idle.

Parameters:
- DATA_W, 8, unsigned pixel width.
- WEIGHT_W, 8, signed kernel weight width.
- ROW_LEN, 8, pixels per row, equal to BRAM depth. Minimum 3; address width is clog2(ROW_LEN), so 3 at the default.
- ACC_W, DATA_W+WEIGHT_W+5, signed result width (product plus 4 guard bits for 9 terms).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_compute_conv  in  1  start pulse from the controller.
- i_wgt_wr  in  1  weight write strobe.
- i_wgt_addr  in  4  weight index 0..8, row-major: w[r][c] at 3r+c, c=0 is the leftmost/oldest column.
- i_wgt_data  in  WEIGHT_W  signed weight.
- i_row0_data, i_row1_data, i_row2_data  in  DATA_W  BRAM read data, 1-cycle read latency.
- o_rd_en  out  1  BRAM read enable.
- o_rd_addr  out  clog2(ROW_LEN)  column address shared by all three BRAMs.
- o_busy  out  1  high from accept until done.
- o_result  out  ACC_W  signed convolution result.
- o_result_valid  out  1  o_result qualifier.
- o_conv_done  out  1  one-cycle pulse to the controller.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, window, pipeline and all 9 weights cleared to 0.
- Reset mid-operation aborts the operation: no done pulse, next cycle IDLE.
- FSM states:
  - IDLE: i_compute_conv=1 goes to READ; column counter k=0; o_busy=1 from the next cycle.
  - READ: o_rd_en=1, o_rd_addr=k, k increments each cycle. After k=ROW_LEN-1 is issued, go to DRAIN.
  - DRAIN: wait until the last result is valid, then go to IDLE. o_busy=0 the cycle after o_conv_done.
- Data path and timing:
  - Cycle t presents address j. At cycle t+1 the BRAM data is valid and is shifted into the window at that edge (column 2 takes new data, columns move 2→1→0).
  - Cycle t+2: window is complete if j>=2.
  - Stage 1 registers the 9 products at the end of t+2.
  - Stage 2 registers the adder-tree sum at the end of t+3.
  - Result: o_result_valid=1 and o_result valid in cycle t+4.
- Result formula: result_j = sum over r,c of w[r][c]*row_r[j-2+c], for j=2..ROW_LEN-1, giving ROW_LEN-2 results on consecutive cycles.
  - Pixels are zero-extended to signed before multiplying.
  - Full precision throughout; no saturation or truncation.
- Valid tracking: a valid bit travels with each column. Windows with j<2 never assert o_result_valid.
- o_conv_done: asserted in the same cycle as the last o_result_valid (j=ROW_LEN-1).
- o_result holds its last value when o_result_valid=0.
- i_compute_conv while o_busy=1: ignored; no queueing.
- Weight writes:
  - Accepted only in IDLE, effective at the next edge.
  - Ignored while busy, so weights are frozen during an operation.
  - i_wgt_addr>=9 is ignored.
- i_compute_conv and i_wgt_wr in the same IDLE cycle: the write completes and the operation starts; the new weight is used.
- Window is not cleared between operations; each operation refills all 3 columns before producing any result.

Decomposition:
- Shared package conv_pkg: DATA_W, WEIGHT_W, ACC_W defaults, the FSM state enum (IDLE/READ/DRAIN), and the kernel size constant KSIZE=3.
- One sub-module, conv3x3_dot: 9 registered multiplies plus a registered adder tree, fixed 2-cycle latency, with a valid bit passed through.
- Top level holds the FSM, address counter, window registers and weight file.

Test Plan:
- Weights all 1, each row's BRAM word at address a = a+1, ROW_LEN=8, pulse start:
  - o_rd_addr sequences 0..7 on consecutive cycles.
  - Results are 18,27,36,45,54,63 on 6 consecutive valid cycles.
  - o_conv_done coincides with 63; first valid arrives 4 cycles after o_rd_addr=2.
- Identity kernel (w[1][1]=1, others 0), row1 data = 10*a, other rows 0xFF → results 10,20,30,40,50,60.
- All weights -1, all pixels 255 → every result is -2295 (sign-extended to ACC_W); no overflow.
- Start pulse repeated mid-operation, plus a weight write while busy → single done pulse, results unchanged; new weight ignored.
- Assert i_rst during READ at k=4 → next cycle all outputs 0, no done pulse, weights 0. A subsequent load and start completes normally.
- Back-to-back operations: start issued the cycle after o_busy falls → second run produces identical results and timing.
